// File: rtl/aes_dec_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_dec_round_ctrl
//
// Iterative sequencer for a single-round AES-128 inverse-cipher datapath.
// A ciphertext block is accepted and whitened with round key NR. The external
// combinational round unit (invShiftRows, invSubBytes, AddRoundKey,
// invMixColumns with final-round bypass) is then applied NR times with round
// keys NR-1 down to 0. The plaintext is returned over a valid/ready handshake.
//
// Optional feature: define AES_DEC_CTRL_KEYSTALL_EN to add an rk_valid input.
// While rk_valid is low in LOAD/ROUND the controller holds all state, so the
// key store may take extra cycles to answer. Without the macro, rk_data is
// taken as valid every cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   ciphertext block offered
//   in_ready   controller can accept a block (IDLE, or DONE with out_ready)
//   in_data    ciphertext, byte 0 at [127:120], column-major
//   out_valid  plaintext available (DONE)
//   out_ready  consumer accepts plaintext
//   out_data   plaintext, zero whenever out_valid is low
//   rk_idx     round-key index requested this cycle (0 when not busy)
//   rk_data    round key for rk_idx, same cycle
//   rk_valid   (AES_DEC_CTRL_KEYSTALL_EN only) rk_data is valid this cycle
//   ru_state   state fed to the round unit
//   ru_key     key fed to the round unit (rk_data passed through)
//   ru_final   round-unit final-round select (last round only)
//   ru_result  round-unit output
//   busy       high in LOAD or ROUND
// -----------------------------------------------------------------------------
module aes_dec_round_ctrl #(
    parameter int unsigned NR     = 10,
    parameter int unsigned KIDX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [127:0]      rk_data,
`ifdef AES_DEC_CTRL_KEYSTALL_EN
    input  logic              rk_valid,
`endif
    output logic [127:0]      ru_state,
    output logic [127:0]      ru_key,
    output logic              ru_final,
    input  logic [127:0]      ru_result,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] KIDX_FIRST_ROUND = KIDX_W'(NR - 1);

    state_e              fsm_q, fsm_d;
    logic [127:0]        state_reg_q, state_reg_d;
    logic [KIDX_W-1:0]   cnt_q, cnt_d;
    logic                key_ok;

`ifdef AES_DEC_CTRL_KEYSTALL_EN
    assign key_ok = rk_valid;
`else
    assign key_ok = 1'b1;
`endif

    // The round unit always sees the working state and the fetched key.
    assign ru_state = state_reg_q;
    assign ru_key   = rk_data;

    // NOTE: every variable this block writes gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        fsm_d       = fsm_q;
        state_reg_d = state_reg_q;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        rk_idx      = '0;
        ru_final    = 1'b0;
        busy        = 1'b0;

        unique case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_reg_d = in_data;
                    fsm_d       = ST_LOAD;
                end
            end

            ST_LOAD: begin
                busy   = 1'b1;
                rk_idx = KIDX_LAST;
                // Initial whitening with the last round key.
                if (key_ok) begin
                    state_reg_d = state_reg_q ^ rk_data;
                    cnt_d       = KIDX_FIRST_ROUND;
                    fsm_d       = ST_ROUND;
                end
            end

            ST_ROUND: begin
                busy     = 1'b1;
                rk_idx   = cnt_q;
                ru_final = (cnt_q == '0);
                if (key_ok) begin
                    state_reg_d = ru_result;
                    // Decrement only while nonzero; cnt never wraps.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        fsm_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                out_data  = state_reg_q;
                // Handing off the result frees the register the same cycle,
                // so a waiting block can be taken back-to-back.
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_reg_d = in_data;
                        fsm_d       = ST_LOAD;
                    end else begin
                        fsm_d = ST_IDLE;
                    end
                end
            end

            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    // NOTE: the 128-bit state register is reset as well. It feeds ru_state
    // directly, and a reset mid-block must leave no trace of the discarded data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= ST_IDLE;
            state_reg_q <= '0;
            cnt_q       <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_reg_q <= state_reg_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
